// File: rtl/uart_dac_pkg.sv
// uart_dac_pkg: shared state types, frame constants and rate helpers for the UART-to-DAC path
package uart_dac_pkg;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HEAD, P_HI, P_LO} parser_state_t;
  localparam logic [7:0] FRAME_HEAD = 8'hA5;
  function automatic int bit_cnt(input int clk_fre, input int uart_rate);
    return clk_fre * 1000000 / uart_rate;
  endfunction
  function automatic int dac_half(input int clk_fre, input int dac_fre);
    return clk_fre * 1000000 / (2 * dac_fre);
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchroniser; flags good bytes and bad stop bits
module uart_rx_byte
  import uart_dac_pkg::*;
#(
  parameter int BIT_CNT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);
  localparam int CW = $clog2(BIT_CNT);
  rx_state_t state, state_next;
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic rx_s, tick, half_tick;
  assign rx_s = sync[1];
  assign tick = cnt == CW'(BIT_CNT - 1);
  assign half_tick = cnt == CW'(BIT_CNT / 2 - 1);
  always_comb begin
    state_next = state;
    case (state)
      R_IDLE:  state_next = (sync[2] && !rx_s) ? R_START : R_IDLE;
      R_START: state_next = half_tick ? (rx_s ? R_IDLE : R_DATA) : R_START;
      R_DATA:  state_next = (tick && bit_idx == 3'd7) ? R_STOP : R_DATA;
      R_STOP:  state_next = tick ? R_IDLE : R_STOP;
      default: state_next = R_IDLE;
    endcase
  end
  // sync[1:0] is the two-flop synchroniser, sync[2] the previous sample for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync       <= '1;
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      sync       <= {sync[1:0], rx};
      state      <= state_next;
      cnt        <= (state == R_IDLE || state_next != state || tick) ? '0 : cnt + 1'b1;
      if (state == R_DATA && tick) begin
        byte_data <= {rx_s, byte_data[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
      byte_valid <= state == R_STOP && tick && rx_s;
      stop_err   <= state == R_STOP && tick && !rx_s;
    end
endmodule

// File: rtl/uart_dac_top.sv
// uart_dac_top: decodes A5/HI/LO UART frames into 12-bit codes and drives a parallel DAC
module uart_dac_top
  import uart_dac_pkg::*;
#(
  parameter int          CLK_FRE       = 50,
  parameter int          UART_RATE     = 115200,
  parameter int          DAC_FRE       = 1000000,
  parameter logic [11:0] DAC_INIT      = 12'h000,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [11:0] dac_db,
  output logic        dac_clk,
  output logic        frame_err
);
  localparam int BIT_N  = bit_cnt(CLK_FRE, UART_RATE);
  localparam int HALF   = dac_half(CLK_FRE, DAC_FRE);
  localparam int TO_LIM = TIMEOUT_BYTES * 10 * BIT_N;
  localparam int TW     = $clog2(TO_LIM + 1);
  localparam int DW     = $clog2(HALF + 1);
  logic       byte_valid, stop_err, err_c, timeout;
  logic [7:0] byte_data;
  parser_state_t p_state, p_next;
  logic [3:0]    hi;
  logic [11:0]   pending;
  logic [TW-1:0] idle_cnt;
  logic [DW-1:0] div;
  uart_rx_byte #(.BIT_CNT(BIT_N)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_err  (stop_err)
  );
  assign timeout = idle_cnt == TW'(TO_LIM - 1);
  assign err_c = stop_err || (byte_valid && p_state == P_HI && |byte_data[7:4]);
  always_comb begin
    p_next = p_state;
    if (stop_err) p_next = P_HEAD;
    else if (byte_valid)
      case (p_state)
        P_HEAD:  p_next = (byte_data == FRAME_HEAD) ? P_HI : P_HEAD;
        P_HI:    p_next = |byte_data[7:4] ? P_HEAD : P_LO;
        default: p_next = P_HEAD;
      endcase
    else if (p_state != P_HEAD && timeout) p_next = P_HEAD;
  end
  // idle_cnt measures silence since the last byte while a frame is partially received
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_state   <= P_HEAD;
      hi        <= '0;
      pending   <= DAC_INIT;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      p_state   <= p_next;
      frame_err <= err_c;
      idle_cnt  <= (p_next == P_HEAD || byte_valid) ? '0 : idle_cnt + 1'b1;
      if (byte_valid && p_state == P_HI) hi <= byte_data[3:0];
      if (byte_valid && p_state == P_LO) pending <= {hi, byte_data};
    end
  // the code is loaded as dac_clk falls so it is stable around the DAC's rising-edge latch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div     <= '0;
      dac_clk <= 1'b0;
      dac_db  <= DAC_INIT;
    end else begin
      div <= (div == DW'(HALF - 1)) ? '0 : div + 1'b1;
      if (div == DW'(HALF - 1)) begin
        dac_clk <= ~dac_clk;
        if (dac_clk) dac_db <= pending;
      end
    end
endmodule

// File: tb/tb_uart_dac_top.sv
// tb_uart_dac_top: UART frame stimulus against a byte-level frame model and per-cycle DAC timing checks
module tb_uart_dac_top;
  localparam int BIT_N = 100;
  localparam int HALF  = 25;
  logic        clk = 0, rst_n = 1, uart_rx = 1;
  logic [11:0] dac_db;
  logic        dac_clk, frame_err;
  int vectors = 0, miscompares = 0;
  uart_dac_top #(
    .CLK_FRE(50), .UART_RATE(500000), .DAC_FRE(1000000), .DAC_INIT(12'h000), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .dac_db(dac_db), .dac_clk(dac_clk), .frame_err(frame_err)
  );
  always #10 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  // frame model: bytes collected so far of the current frame, last complete code, error count
  logic [7:0]  mq[$];
  logic [11:0] m_code = 12'h000;
  int          m_err = 0;
  task automatic m_byte(input logic [7:0] b);
    if (mq.size() == 0) begin
      if (b == 8'hA5) mq.push_back(b);
    end else if (mq.size() == 1) begin
      if (b > 8'h0F) begin m_err++; mq.delete(); end
      else mq.push_back(b);
    end else begin
      m_code = {mq[1][3:0], b};
      mq.delete();
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 0;
    repeat (BIT_N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_N) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT_N) @(negedge clk);
    uart_rx = 1;
  endtask
  task automatic tx(input logic [7:0] b);
    send_byte(b);
    m_byte(b);
  endtask
  task automatic settle(input string name);
    logic last;
    bit seen;
    last = dac_clk;
    seen = 0;
    for (int k = 0; k < 2 * HALF + 5 && !seen; k++) begin
      @(negedge clk);
      seen = last && !dac_clk;
      last = dac_clk;
    end
    check({name, " dac_clk fall seen"}, int'(seen), 1);
    check(name, dac_db, m_code);
  endtask
  // per-cycle monitor: dac_clk phase from posedges since reset, dac_db moves only as dac_clk falls
  int  n = 0, err_cnt = 0;
  bit  armed = 0;
  logic p_clk, p_err;
  logic [11:0] p_db;
  always @(posedge clk or negedge rst_n) n <= !rst_n ? 0 : n + 1;
  always @(negedge clk) begin
    if (!rst_n) armed = 0;
    else begin
      check("dac_clk phase", dac_clk, (n / HALF) % 2);
      if (armed && dac_db != p_db) check("dac_db change off dac_clk fall", int'(p_clk && !dac_clk), 1);
      if (frame_err) begin
        err_cnt++;
        if (armed) check("frame_err width", p_err, 0);
      end
      armed = 1;
      p_clk = dac_clk;
      p_db  = dac_db;
      p_err = frame_err;
    end
  end
  int e0;
  initial begin
    #5 rst_n = 0;
    #1;
    check("reset dac_db", dac_db, 12'h000);
    check("reset dac_clk", dac_clk, 0);
    check("reset frame_err", frame_err, 0);
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (2 * BIT_N) @(negedge clk);
    // 1: basic frame
    e0 = err_cnt;
    tx(8'hA5); tx(8'h08); tx(8'h00);
    settle("t1 code");
    check("t1 literal", dac_db, 12'h800);
    check("t1 no frame_err", err_cnt - e0, 0);
    // 2: leading garbage
    e0 = err_cnt;
    tx(8'h12); tx(8'h34); tx(8'hA5); tx(8'h0F); tx(8'hFF);
    settle("t2 code");
    check("t2 literal", dac_db, 12'hFFF);
    check("t2 no frame_err", err_cnt - e0, 0);
    // 3: bad HI nibble
    e0 = err_cnt;
    tx(8'hA5); tx(8'h1F);
    check("t3 frame_err on HI", err_cnt - e0, 1);
    tx(8'h00);
    settle("t3 unchanged");
    check("t3 unchanged literal", dac_db, 12'hFFF);
    tx(8'hA5); tx(8'h01); tx(8'h23);
    settle("t3 code");
    check("t3 literal", dac_db, 12'h123);
    // 4: stop bit forced low
    e0 = err_cnt;
    tx(8'hA5);
    send_byte(8'h02, 1'b0);
    m_err++;
    mq.delete();
    repeat (BIT_N) @(negedge clk);
    check("t4 frame_err on stop", err_cnt - e0, 1);
    settle("t4 unchanged");
    tx(8'hA5); tx(8'h02); tx(8'h34);
    settle("t4 code");
    check("t4 literal", dac_db, 12'h234);
    // 5: short low glitch
    e0 = err_cnt;
    uart_rx = 0;
    repeat (BIT_N / 4) @(negedge clk);
    uart_rx = 1;
    repeat (3 * BIT_N) @(negedge clk);
    check("t5 no frame_err", err_cnt - e0, 0);
    settle("t5 unchanged");
    // 6: inter-byte timeout
    e0 = err_cnt;
    tx(8'hA5); tx(8'h08);
    repeat (5 * 10 * BIT_N) @(negedge clk);
    mq.delete();
    tx(8'h00);
    settle("t6 after timeout");
    check("t6 no 08 output", dac_db, 12'h234);
    tx(8'hA5); tx(8'h04); tx(8'h56);
    settle("t6 code");
    check("t6 literal", dac_db, 12'h456);
    check("t6 no frame_err", err_cnt - e0, 0);
    // reset in the middle of a LO byte
    tx(8'hA5); tx(8'h01);
    uart_rx = 0;
    repeat (BIT_N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      repeat (BIT_N) @(negedge clk);
    end
    #3 rst_n = 0;
    #1;
    check("mid-byte reset dac_db", dac_db, 12'h000);
    check("mid-byte reset dac_clk", dac_clk, 0);
    mq.delete();
    m_code = 12'h000;
    uart_rx = 1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (2 * BIT_N) @(negedge clk);
    settle("post-reset hold");
    tx(8'hA5); tx(8'h07); tx(8'h89);
    settle("post-reset code");
    check("post-reset literal", dac_db, 12'h789);
    check("frame_err total", err_cnt, m_err);
    check("frame_err total literal", err_cnt, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
